// File: rtl/audio_player_pkg.sv
// -----------------------------------------------------------------------------
// audio_player_pkg
// Shared definitions for the multi-voice audio player:
//   - clip_id_t     : clip identifiers in the concatenated sample ROM
//   - DEF_CLIP_*    : default clip start/length tables (packed, clip 0 in LSBs)
//   - seq_state_t   : sample sequencer FSM states
//   - clog2_min1    : $clog2 that never returns 0 (for index widths)
// -----------------------------------------------------------------------------
package audio_player_pkg;

    typedef enum logic [1:0] {
        CLIP_CHOMP = 2'd0,
        CLIP_INTRO = 2'd1,
        CLIP_DEATH = 2'd2
    } clip_id_t;

    localparam int DEF_NUM_CLIPS = 3;
    localparam int DEF_ADDR_W    = 16;

    // Clips are stored back to back, so each start is the running sum of
    // the previous lengths.
    localparam logic [DEF_NUM_CLIPS*DEF_ADDR_W-1:0] DEF_CLIP_START =
        {16'd18014, 16'd5735, 16'd0};
    localparam logic [DEF_NUM_CLIPS*DEF_ADDR_W-1:0] DEF_CLIP_LEN =
        {16'd33735, 16'd12279, 16'd5735};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_MIX   = 2'd3
    } seq_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/audio_player_voice.sv
// -----------------------------------------------------------------------------
// audio_voice
// One playback voice: active/loop/clip/offset registers, request acceptance
// and end-of-clip handling.
// Ports:
//   clk_25MHZ   in   clock
//   rst_n       in   asynchronous active-low reset
//   accept_en   in   sequencer idle; requests and stop are only honoured here
//   play_valid  in   play request
//   play_clip   in   CLIP_W clip id
//   play_loop   in   1 = loop, 0 = one-shot
//   stop        in   level stop
//   advance     in   one-cycle step of the offset (sequencer MIX state)
//   active      out  voice is playing
//   clip        out  current clip id
//   offset      out  current offset within the clip
//   done        out  one-cycle pulse when a one-shot reaches its end
// -----------------------------------------------------------------------------
module audio_voice
    import audio_player_pkg::*;
#(
    parameter int                          NUM_CLIPS = 3,
    parameter int                          CLIP_W    = 2,
    parameter int                          ADDR_W    = 16,
    parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_LEN  = DEF_CLIP_LEN
) (
    input  logic              clk_25MHZ,
    input  logic              rst_n,
    input  logic              accept_en,
    input  logic              play_valid,
    input  logic [CLIP_W-1:0] play_clip,
    input  logic              play_loop,
    input  logic              stop,
    input  logic              advance,
    output logic              active,
    output logic [CLIP_W-1:0] clip,
    output logic [ADDR_W-1:0] offset,
    output logic              done
);

    logic [ADDR_W-1:0] len_tbl [NUM_CLIPS];
    logic              loop_reg;
    logic              play_fire;
    logic              clip_ok;
    logic [ADDR_W-1:0] last_offset;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIPS; gi++) begin : g_len
            assign len_tbl[gi] = CLIP_LEN[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    assign play_fire   = play_valid & accept_en;
    assign clip_ok     = ({1'b0, play_clip} < (CLIP_W+1)'(NUM_CLIPS));
    assign last_offset = len_tbl[clip] - 1'b1;

    always_ff @(posedge clk_25MHZ or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            loop_reg <= 1'b0;
            clip     <= '0;
            offset   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (play_fire) begin
                // An accepted request always masks stop; an out-of-range clip
                // is swallowed without touching the voice.
                if (clip_ok) begin
                    active   <= 1'b1;
                    loop_reg <= play_loop;
                    clip     <= play_clip;
                    offset   <= '0;
                end
            end else if (accept_en && stop) begin
                active <= 1'b0;
            end else if (advance && active) begin
                if (offset == last_offset) begin
                    if (loop_reg) begin
                        offset <= '0;
                    end else begin
                        active <= 1'b0;
                        done   <= 1'b1;
                    end
                end else begin
                    offset <= offset + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm.sv
// -----------------------------------------------------------------------------
// pwm
// Free-running W-bit PWM. The duty value is latched at the end of each carrier
// period so a mid-period update never produces a runt pulse.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   duty     in   W-bit duty value (0 = always low)
//   pwm_out  out  PWM output
// -----------------------------------------------------------------------------
module pwm #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] duty,
    output logic         pwm_out
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] duty_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            duty_reg <= '0;
            pwm_out  <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == '1) begin
                duty_reg <= duty;
            end
            pwm_out <= (cnt_reg < duty_reg);
        end
    end

endmodule

// File: rtl/single_port_bram_with_rst.sv
// -----------------------------------------------------------------------------
// single_port_bram_with_rst
// Single-port block RAM with registered read and synchronous output clear.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high clear of the read register
//   we    in   write enable
//   addr  in   ADDR_W address
//   din   in   DATA_W write data
//   dout  out  DATA_W read data, one cycle after addr
// -----------------------------------------------------------------------------
module single_port_bram_with_rst #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 51749,
    parameter int ADDR_W    = 16,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The image name is carried for the device build flow, which attaches it
    // as the power-up contents of this array.
    logic unused_init_file;
    assign unused_init_file = ^INIT_FILE;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/audio_player.sv
// -----------------------------------------------------------------------------
// audio_player
// Multi-voice sample player. On each sample strobe the sequencer reads one
// sample per voice from the shared clip ROM, sums the centred samples with
// saturation, registers the mix and drives the PWM output.
// Ports:
//   clk_25MHZ   in   system clock
//   rst_n       in   asynchronous active-low reset
//   sample_stb  in   one-cycle sample-rate strobe
//   play_valid  in   per-voice play request
//   play_ready  out  per-voice request ready (sequencer idle)
//   play_clip   in   per-voice clip id, voice v at [v*CLIP_W +: CLIP_W]
//   play_loop   in   per-voice loop flag
//   stop        in   per-voice level stop
//   busy        out  per-voice active
//   done        out  per-voice one-shot completion pulse
//   mix_sample  out  registered mixed sample
//   mix_valid   out  one-cycle pulse when mix_sample updates
//   pwm_out     out  PWM audio
//   en          out  amplifier enable (any voice busy)
// -----------------------------------------------------------------------------
module audio_player
    import audio_player_pkg::*;
#(
    parameter int                          NUM_VOICES = 2,
    parameter int                          NUM_CLIPS  = 3,
    parameter int                          SAMPLE_W   = 8,
    parameter int                          ADDR_W     = 16,
    parameter int                          ROM_DEPTH  = 51749,
    parameter                              MEM_FILE   = "mem/Sounds.mem",
    parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_START = DEF_CLIP_START,
    parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_LEN   = DEF_CLIP_LEN,
    localparam int                         CLIP_W     = clog2_min1(NUM_CLIPS)
) (
    input  logic                         clk_25MHZ,
    input  logic                         rst_n,
    input  logic                         sample_stb,
    input  logic [NUM_VOICES-1:0]        play_valid,
    output logic [NUM_VOICES-1:0]        play_ready,
    input  logic [NUM_VOICES*CLIP_W-1:0] play_clip,
    input  logic [NUM_VOICES-1:0]        play_loop,
    input  logic [NUM_VOICES-1:0]        stop,
    output logic [NUM_VOICES-1:0]        busy,
    output logic [NUM_VOICES-1:0]        done,
    output logic [SAMPLE_W-1:0]          mix_sample,
    output logic                         mix_valid,
    output logic                         pwm_out,
    output logic                         en
);

    localparam int VIDX_W = clog2_min1(NUM_VOICES);
    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam logic [VIDX_W-1:0]   FIDX_LAST = VIDX_W'(NUM_VOICES - 1);
    localparam logic [SAMPLE_W-1:0] MID       = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_HI =
        ACC_W'({1'b0, {(SAMPLE_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    // ---------------- Sequencer FSM ----------------
    seq_state_t        state_reg, state_next;
    logic [VIDX_W-1:0] fidx_reg, fidx_next;
    logic              seq_start;
    logic              seq_idle;
    logic              seq_mix;

    always_ff @(posedge clk_25MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            fidx_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fidx_reg  <= fidx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fidx_next  = '0;
        seq_start  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (sample_stb) begin
                    state_next = ST_FETCH;
                    seq_start  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (fidx_reg == FIDX_LAST) begin
                    state_next = ST_DRAIN;
                end else begin
                    fidx_next = fidx_reg + 1'b1;
                end
            end
            ST_DRAIN: state_next = ST_MIX;
            ST_MIX:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign seq_idle   = (state_reg == ST_IDLE);
    assign seq_mix    = (state_reg == ST_MIX);
    assign play_ready = {NUM_VOICES{seq_idle}};

    // ---------------- Voices ----------------
    logic [NUM_VOICES-1:0] voice_active;
    logic [CLIP_W-1:0]     voice_clip   [NUM_VOICES];
    logic [ADDR_W-1:0]     voice_offset [NUM_VOICES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            audio_voice #(
                .NUM_CLIPS (NUM_CLIPS),
                .CLIP_W    (CLIP_W),
                .ADDR_W    (ADDR_W),
                .CLIP_LEN  (CLIP_LEN)
            ) u_voice (
                .clk_25MHZ  (clk_25MHZ),
                .rst_n      (rst_n),
                .accept_en  (seq_idle),
                .play_valid (play_valid[gi]),
                .play_clip  (play_clip[gi*CLIP_W +: CLIP_W]),
                .play_loop  (play_loop[gi]),
                .stop       (stop[gi]),
                .advance    (seq_mix),
                .active     (voice_active[gi]),
                .clip       (voice_clip[gi]),
                .offset     (voice_offset[gi]),
                .done       (done[gi])
            );
        end
    endgenerate

    assign busy = voice_active;
    assign en   = |voice_active;

    // ---------------- ROM ----------------
    logic [ADDR_W-1:0]   start_tbl [NUM_CLIPS];
    logic [ADDR_W-1:0]   rom_addr;
    logic [SAMPLE_W-1:0] rom_dout;

    generate
        for (gi = 0; gi < NUM_CLIPS; gi++) begin : g_start
            assign start_tbl[gi] = CLIP_START[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Address tracks the voice being fetched; outside FETCH it is don't-care.
    assign rom_addr = start_tbl[voice_clip[fidx_reg]] + voice_offset[fidx_reg];

    single_port_bram_with_rst #(
        .DATA_W    (SAMPLE_W),
        .DEPTH     (ROM_DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (MEM_FILE)
    ) u_rom (
        .clk  (clk_25MHZ),
        .rst  (1'b0),
        .we   (1'b0),
        .addr (rom_addr),
        .din  ({SAMPLE_W{1'b0}}),
        .dout (rom_dout)
    );

    // ---------------- Mixer ----------------
    // rd_valid_reg/rd_vidx_reg follow the ROM's one-cycle latency so each
    // returned sample is credited to the voice that requested it.
    logic                     rd_valid_reg;
    logic [VIDX_W-1:0]        rd_vidx_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  rom_ext, mid_ext, contrib, acc_sat;
    logic [SAMPLE_W-1:0]      mix_next;
    logic [SAMPLE_W-1:0]      mix_sample_reg;
    logic                     mix_valid_reg;

    assign rom_ext = signed'({{(ACC_W-SAMPLE_W){1'b0}}, rom_dout});
    assign mid_ext = signed'({{(ACC_W-SAMPLE_W){1'b0}}, MID});
    assign contrib = voice_active[rd_vidx_reg] ? (rom_ext - mid_ext) : '0;

    always_comb begin
        acc_sat = acc_reg;
        if (acc_reg > SAT_HI) begin
            acc_sat = SAT_HI;
        end else if (acc_reg < SAT_LO) begin
            acc_sat = SAT_LO;
        end
        // Low bits of the clamped two's-complement value plus the midpoint
        // give the unsigned output sample.
        mix_next = acc_sat[SAMPLE_W-1:0] + MID;
    end

    always_ff @(posedge clk_25MHZ or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg   <= 1'b0;
            rd_vidx_reg    <= '0;
            acc_reg        <= '0;
            mix_sample_reg <= MID;
            mix_valid_reg  <= 1'b0;
        end else begin
            rd_valid_reg  <= (state_reg == ST_FETCH);
            rd_vidx_reg   <= fidx_reg;
            mix_valid_reg <= 1'b0;
            if (seq_start) begin
                acc_reg <= '0;
            end else if (rd_valid_reg) begin
                acc_reg <= acc_reg + contrib;
            end
            if (seq_mix) begin
                mix_sample_reg <= mix_next;
                mix_valid_reg  <= 1'b1;
            end
        end
    end

    assign mix_sample = mix_sample_reg;
    assign mix_valid  = mix_valid_reg;

    pwm #(
        .W (SAMPLE_W)
    ) u_pwm (
        .clk     (clk_25MHZ),
        .rst_n   (rst_n),
        .duty    (mix_sample_reg),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_audio_player.sv
// -----------------------------------------------------------------------------
// tb_audio_player
// Directed bench for audio_player with a small clip table:
//   clip 0 @0 len 4 : 90 A0 B0 C0
//   clip 1 @4 len 2 : 70 60
//   clip 2 @6 len 3 : F0 10 F0
// Expected mixes are queued when a strobe is issued and checked when
// mix_valid arrives.
// -----------------------------------------------------------------------------
module tb_audio_player;

    logic       clk_25MHZ = 1'b0;
    logic       rst_n;
    logic       sample_stb;
    logic [1:0] play_valid;
    logic [1:0] play_ready;
    logic [3:0] play_clip;
    logic [1:0] play_loop;
    logic [1:0] stop;
    logic [1:0] busy;
    logic [1:0] done;
    logic [7:0] mix_sample;
    logic       mix_valid;
    logic       pwm_out;
    logic       en;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];

    always #20 clk_25MHZ = ~clk_25MHZ;

    audio_player #(
        .NUM_VOICES (2),
        .NUM_CLIPS  (3),
        .SAMPLE_W   (8),
        .ADDR_W     (16),
        .ROM_DEPTH  (51749),
        .MEM_FILE   ("mem/test_clips.mem"),
        .CLIP_START ({16'd6, 16'd4, 16'd0}),
        .CLIP_LEN   ({16'd3, 16'd2, 16'd4})
    ) dut (
        .clk_25MHZ  (clk_25MHZ),
        .rst_n      (rst_n),
        .sample_stb (sample_stb),
        .play_valid (play_valid),
        .play_ready (play_ready),
        .play_clip  (play_clip),
        .play_loop  (play_loop),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .mix_sample (mix_sample),
        .mix_valid  (mix_valid),
        .pwm_out    (pwm_out),
        .en         (en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [1:0] vmask, input logic [1:0] c0, input logic [1:0] c1,
                           input logic [1:0] lmask, input logic [1:0] smask);
        @(negedge clk_25MHZ);
        play_valid = vmask;
        play_clip  = {c1, c0};
        play_loop  = lmask;
        stop       = smask;
        @(negedge clk_25MHZ);
        play_valid = '0;
        stop       = '0;
    endtask

    // Called on the falling edge right after the strobe was sampled.
    task automatic wait_mix(input string tag, input logic [1:0] exp_done, input logic [1:0] exp_busy);
        int         k;
        logic [7:0] want;
        k = 0;
        check({tag, "_ready_low"}, 32'(play_ready), 32'h0);
        while (mix_valid !== 1'b1 && k < 12) begin
            @(negedge clk_25MHZ);
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'd4);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check({tag, "_mix"}, 32'(mix_sample), 32'(want));
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        check({tag, "_en"}, 32'(en), 32'(|exp_busy));
        @(negedge clk_25MHZ);
        check({tag, "_valid_pulse"}, 32'({mix_valid, done}), 32'h0);
    endtask

    task automatic strobe(input string tag, input logic [7:0] exp_mix,
                          input logic [1:0] exp_done, input logic [1:0] exp_busy);
        exp_q.push_back(exp_mix);
        @(negedge clk_25MHZ);
        sample_stb = 1'b1;
        @(negedge clk_25MHZ);
        sample_stb = 1'b0;
        wait_mix(tag, exp_done, exp_busy);
    endtask

    initial begin
        logic [7:0] img [9];
        int         vcount;
        img = '{8'h90, 8'hA0, 8'hB0, 8'hC0, 8'h70, 8'h60, 8'hF0, 8'h10, 8'hF0};
        for (int i = 0; i < 9; i++) begin
            dut.u_rom.mem[i] = img[i];
        end

        rst_n      = 1'b0;
        sample_stb = 1'b0;
        play_valid = '0;
        play_clip  = '0;
        play_loop  = '0;
        stop       = '0;
        repeat (3) @(negedge clk_25MHZ);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_done",  32'(done), 32'h0);
        check("rst_valid", 32'(mix_valid), 32'h0);
        check("rst_en",    32'(en), 32'h0);
        check("rst_mix",   32'(mix_sample), 32'h80);
        check("rst_ready", 32'(play_ready), 32'h3);
        rst_n = 1'b1;

        // One-shot clip 0 on voice 0
        request(2'b01, 2'd0, 2'd0, 2'b00, 2'b00);
        check("os_busy", 32'(busy), 32'h1);
        strobe("os0", 8'h90, 2'b00, 2'b01);
        strobe("os1", 8'hA0, 2'b00, 2'b01);
        strobe("os2", 8'hB0, 2'b00, 2'b01);
        strobe("os3", 8'hC0, 2'b01, 2'b00);
        strobe("os4", 8'h80, 2'b00, 2'b00);

        // Looping clip 1 on voice 0
        request(2'b01, 2'd1, 2'd0, 2'b01, 2'b00);
        strobe("lp0", 8'h70, 2'b00, 2'b01);
        strobe("lp1", 8'h60, 2'b00, 2'b01);
        strobe("lp2", 8'h70, 2'b00, 2'b01);
        strobe("lp3", 8'h60, 2'b00, 2'b01);
        strobe("lp4", 8'h70, 2'b00, 2'b01);
        request(2'b00, 2'd0, 2'd0, 2'b00, 2'b01);
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_done", 32'(done), 32'h0);

        // Two voices mixing, voice 1 ends first
        request(2'b11, 2'd0, 2'd1, 2'b00, 2'b00);
        strobe("dual0", 8'h80, 2'b00, 2'b11);
        strobe("dual1", 8'h80, 2'b10, 2'b01);
        strobe("dual2", 8'hB0, 2'b00, 2'b01);
        strobe("dual3", 8'hC0, 2'b01, 2'b00);

        // Saturation both ways
        request(2'b11, 2'd2, 2'd2, 2'b00, 2'b00);
        strobe("sat_hi", 8'hFF, 2'b00, 2'b11);
        strobe("sat_lo", 8'h00, 2'b00, 2'b11);
        strobe("sat_end", 8'hFF, 2'b11, 2'b00);

        // Retrigger mid-clip
        request(2'b01, 2'd0, 2'd0, 2'b00, 2'b00);
        strobe("rt0", 8'h90, 2'b00, 2'b01);
        strobe("rt1", 8'hA0, 2'b00, 2'b01);
        request(2'b01, 2'd0, 2'd0, 2'b00, 2'b00);
        strobe("rt2", 8'h90, 2'b00, 2'b01);

        // Play and stop together: play wins and restarts
        request(2'b01, 2'd1, 2'd0, 2'b01, 2'b01);
        check("ps_busy", 32'(busy), 32'h1);
        strobe("ps0", 8'h70, 2'b00, 2'b01);

        // Out-of-range clip on idle voice 1 is consumed silently
        request(2'b10, 2'd0, 2'd3, 2'b00, 2'b00);
        check("badclip_busy", 32'(busy), 32'h1);

        // Play accepted on the same edge the strobe is sampled
        exp_q.push_back(8'h90);
        @(negedge clk_25MHZ);
        sample_stb = 1'b1;
        play_valid = 2'b01;
        play_clip  = {2'd0, 2'd0};
        play_loop  = 2'b00;
        @(negedge clk_25MHZ);
        sample_stb = 1'b0;
        play_valid = '0;
        wait_mix("same_edge", 2'b00, 2'b01);

        // Reset one cycle after a strobe
        @(negedge clk_25MHZ);
        sample_stb = 1'b1;
        @(negedge clk_25MHZ);
        sample_stb = 1'b0;
        @(negedge clk_25MHZ);
        #5 rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(busy), 32'h0);
        check("arst_en",    32'(en), 32'h0);
        check("arst_mix",   32'(mix_sample), 32'h80);
        check("arst_ready", 32'(play_ready), 32'h3);
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_25MHZ);
            if (mix_valid === 1'b1 || done !== 2'b00) vcount++;
        end
        check("arst_no_valid", 32'(vcount), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_25MHZ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
